// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath sequencer: instruction field map,
// decoded instruction bundle and issue-state encoding.
package datapath_pkg;

    localparam int INSTR_W     = 33;
    localparam int CONST_W     = 32;
    localparam int REG_IDX_W   = 4;

    localparam int CONST_A_BIT = 32;
    localparam int OP_MSB      = 31;
    localparam int OP_LSB      = 29;
    localparam int FORM_BIT    = 28;
    localparam int VEC_MSB     = 27;
    localparam int VEC_LSB     = 26;
    localparam int A_MSB       = 25;
    localparam int A_LSB       = 22;
    localparam int B_MSB       = 21;
    localparam int B_LSB       = 18;
    localparam int C_MSB       = 17;
    localparam int C_LSB       = 14;
    localparam int D_MSB       = 13;
    localparam int D_LSB       = 10;
    localparam int Y1_MSB      = 9;
    localparam int Y1_LSB      = 6;
    localparam int Y2_MSB      = 5;
    localparam int Y2_LSB      = 2;
    localparam int WRITE_MSB   = 1;
    localparam int WRITE_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RUN        = 2'd1,
        S_WAIT_CONST = 2'd2
    } state_t;

    typedef struct packed {
        logic                         const_a;
        logic [OP_MSB-OP_LSB:0]       op;
        logic                         form;
        logic [VEC_MSB-VEC_LSB:0]     vec;
        logic [REG_IDX_W-1:0]         a;
        logic [REG_IDX_W-1:0]         b;
        logic [REG_IDX_W-1:0]         c;
        logic [REG_IDX_W-1:0]         d;
        logic [REG_IDX_W-1:0]         y1;
        logic [REG_IDX_W-1:0]         y2;
        logic [WRITE_MSB-WRITE_LSB:0] write;
    } instr_t;

    function automatic instr_t decode(input logic [INSTR_W-1:0] w);
        instr_t d;
        d.const_a = w[CONST_A_BIT];
        d.op      = w[OP_MSB:OP_LSB];
        d.form    = w[FORM_BIT];
        d.vec     = w[VEC_MSB:VEC_LSB];
        d.a       = w[A_MSB:A_LSB];
        d.b       = w[B_MSB:B_LSB];
        d.c       = w[C_MSB:C_LSB];
        d.d       = w[D_MSB:D_LSB];
        d.y1      = w[Y1_MSB:Y1_LSB];
        d.y2      = w[Y2_MSB:Y2_LSB];
        d.write   = w[WRITE_MSB:WRITE_LSB];
        return d;
    endfunction

endpackage

// File: rtl/datapath_sequencer_fifo.sv
// Single-clock circular FIFO that exposes its two oldest entries and can
// retire zero, one or two of them per cycle.
module seq_fifo #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 33,
    parameter int NEXT_W = 32,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic [1:0]        pop_n,
    output logic [CW-1:0]     count,
    output logic [WIDTH-1:0]  head,
    output logic [NEXT_W-1:0] head_next
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_1;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign rd_ptr_1  = wrap_inc(rd_ptr);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_1][NEXT_W-1:0];

    // NOTE: storage carries no reset; the count gates every read, so stale
    // contents are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wrap_inc(wr_ptr);
            case (pop_n)
                2'd1:    rd_ptr <= rd_ptr_1;
                2'd2:    rd_ptr <= wrap_inc(rd_ptr_1);
                default: rd_ptr <= rd_ptr;
            endcase
            count <= count + CW'(push) - CW'(pop_n);
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Buffers the instruction stream, pairs const_a instructions with their
// constant word and drives one registered datapath instruction per cycle.
module datapath_sequencer
    import datapath_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [32:0]        in_word,
    input  logic               run,
    input  logic               flush,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_zero_reg,
    output logic [2:0]         op,
    output logic               form,
    output logic [1:0]         vec,
    output logic [3:0]         A,
    output logic [3:0]         B,
    output logic [3:0]         C,
    output logic [3:0]         D,
    output logic [3:0]         Y1,
    output logic [3:0]         Y2,
    output logic [1:0]         write,
    output logic               const_a,
    output logic [31:0]        constant,
    output logic [3:0]         zero_reg,
    output logic               issued,
    output logic               busy,
    output logic [CNT_W-1:0]   issue_count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]      count;
    logic [INSTR_W-1:0] head_word;
    logic [CONST_W-1:0] next_const;
    instr_t             head_instr;
    state_t             state;
    logic               do_issue;
    logic               push;
    logic [1:0]         pop_n;
    instr_t             issue_q;
    logic [CONST_W-1:0] const_q;

    assign in_ready   = (count < CW'(DEPTH));
    assign busy       = (count != '0);
    assign push       = in_valid && in_ready;
    assign head_instr = decode(head_word);

    seq_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (INSTR_W),
        .NEXT_W (CONST_W),
        .CW     (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (in_word),
        .pop_n     (pop_n),
        .count     (count),
        .head      (head_word),
        .head_next (next_const)
    );

    // The issue state is a pure function of the current buffer and run, so an
    // instruction accepted at one edge can issue at the very next one.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state = S_IDLE;
        if (run && count != '0) begin
            if (!head_instr.const_a || count >= CW'(2))
                state = S_RUN;
            else
                state = S_WAIT_CONST;
        end
    end

    assign do_issue = (state == S_RUN) && !flush;
    assign pop_n    = !do_issue ? 2'd0 : (head_instr.const_a ? 2'd2 : 2'd1);

    // Non-issue edges clear every field so the datapath never sees a stale write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q     <= '0;
            const_q     <= '0;
            issued      <= 1'b0;
            issue_count <= '0;
            zero_reg    <= '0;
        end else begin
            if (cfg_we)
                zero_reg <= cfg_zero_reg;
            issued <= do_issue;
            if (do_issue) begin
                issue_q     <= head_instr;
                const_q     <= head_instr.const_a ? next_const : '0;
                issue_count <= issue_count + CNT_W'(1);
            end else begin
                issue_q <= '0;
                const_q <= '0;
            end
        end
    end

    assign const_a  = issue_q.const_a;
    assign op       = issue_q.op;
    assign form     = issue_q.form;
    assign vec      = issue_q.vec;
    assign A        = issue_q.a;
    assign B        = issue_q.b;
    assign C        = issue_q.c;
    assign D        = issue_q.d;
    assign Y1       = issue_q.y1;
    assign Y2       = issue_q.y2;
    assign write    = issue_q.write;
    assign constant = const_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: the driver queues accepted words,
// a negedge monitor predicts issues from the queue and checks every output.
module tb_datapath_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [32:0]      in_word = '0;
    logic             run = 1'b0;
    logic             flush = 1'b0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_zero_reg = '0;
    logic [2:0]       op;
    logic             form;
    logic [1:0]       vec;
    logic [3:0]       A, B, C, D, Y1, Y2;
    logic [1:0]       write;
    logic             const_a;
    logic [31:0]      constant;
    logic [3:0]       zero_reg;
    logic             issued;
    logic             busy;
    logic [CNT_W-1:0] issue_count;

    datapath_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_word(in_word), .run(run), .flush(flush), .cfg_we(cfg_we),
        .cfg_zero_reg(cfg_zero_reg), .op(op), .form(form), .vec(vec),
        .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .write(write),
        .const_a(const_a), .constant(constant), .zero_reg(zero_reg),
        .issued(issued), .busy(busy), .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [32:0] exp_q[$];
    logic [3:0]  exp_zero = '0;
    int          exp_cnt = 0;
    logic        exp_issue = 1'b0;
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: accepted words queue in order; a head issues when run is high,
    // no flush, and it is complete (plain word, or const_a plus its constant).
    initial begin
        logic [32:0] w;
        logic [32:0] cw;
        logic [31:0] cval;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("issued", 64'(issued), 64'(exp_issue));
                if (issued) begin
                    if (exp_q.size() == 0) begin
                        check("issue_without_word", 64'(issued), 64'd0);
                    end else begin
                        w    = exp_q.pop_front();
                        cval = '0;
                        if (w[32]) begin
                            if (exp_q.size() == 0) begin
                                check("const_missing", 64'(issued), 64'd0);
                            end else begin
                                cw   = exp_q.pop_front();
                                cval = cw[31:0];
                            end
                        end
                        check("fields", 64'({const_a, op, form, vec, A, B, C, D, Y1, Y2, write}), 64'(w));
                        check("constant", 64'(constant), 64'(cval));
                        exp_cnt++;
                    end
                end else begin
                    check("idle_fields", 64'({const_a, op, form, vec, A, B, C, D, Y1, Y2, write}), 64'd0);
                    check("idle_constant", 64'(constant), 64'd0);
                end
                check("busy", 64'(busy), 64'(exp_q.size() != 0));
                check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
                check("zero_reg", 64'(zero_reg), 64'(exp_zero));
                check("issue_count", 64'(issue_count), 64'(exp_cnt % (1 << CNT_W)));
            end
            exp_issue = rst_n && run && !flush &&
                        (exp_q.size() >= 2 || (exp_q.size() == 1 && !exp_q[0][32]));
        end
    end

    // One clock: capture what the DUT accepts at the coming edge, then update the model.
    task automatic step();
        logic        acc, fl, rs, we;
        logic [32:0] w;
        logic [3:0]  cz;
        @(negedge clk);
        acc = in_valid && in_ready;
        w   = in_word;
        fl  = flush;
        rs  = rst_n;
        we  = cfg_we;
        cz  = cfg_zero_reg;
        @(posedge clk);
        if (!rs) begin
            exp_q.delete();
            exp_zero = '0;
            exp_cnt  = 0;
        end else begin
            if (fl) exp_q.delete();
            else if (acc) exp_q.push_back(w);
            if (we) exp_zero = cz;
        end
        #1;
    endtask

    task automatic push_word(input logic [32:0] w);
        in_valid = 1'b1;
        in_word  = w;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [32:0] rand_plain();
        return {1'b0, 32'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0;
        step();
        mon_en = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Single plain instruction: op=3, A=2, B=4, Y1=7, write=1.
        run = 1'b1;
        push_word({1'b0, 3'd3, 1'b0, 2'd0, 4'd2, 4'd4, 4'd0, 4'd0, 4'd7, 4'd0, 2'd1});
        repeat (3) step();

        // const_a instruction waits for its constant word.
        push_word({1'b1, 3'd0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 2'd1});
        repeat (3) step();
        push_word({1'b0, 32'd5});
        repeat (3) step();

        // Fill while held, one refused push, then drain back to back.
        run = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_word(rand_plain());
        run = 1'b1;
        repeat (6) step();

        // Flush with a simultaneous push.
        run = 1'b0;
        for (int i = 0; i < 3; i++) push_word(rand_plain());
        flush = 1'b1;
        push_word(rand_plain());
        flush = 1'b0;
        repeat (2) step();

        // zero_reg update while issuing.
        run = 1'b1;
        cfg_we = 1'b1;
        cfg_zero_reg = 4'hE;
        push_word(rand_plain());
        cfg_we = 1'b0;
        push_word(rand_plain());
        repeat (2) step();

        // Reset with words buffered and an issue on the outputs.
        run = 1'b0;
        for (int i = 0; i < 3; i++) push_word(rand_plain());
        run = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run = 1'b0;
        repeat (2) step();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 9) < 7);
            in_word      = {($urandom_range(0, 3) == 0), 32'($urandom)};
            run          = ($urandom_range(0, 9) < 8);
            flush        = ($urandom_range(0, 49) == 0);
            cfg_we       = ($urandom_range(0, 19) == 0);
            cfg_zero_reg = 4'($urandom);
            rst_n        = ($urandom_range(0, 199) != 0);
            step();
        end

        in_valid = 1'b0;
        flush    = 1'b0;
        cfg_we   = 1'b0;
        rst_n    = 1'b1;
        run      = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Feeds the register-file datapath one decoded instruction per cycle from a buffered instruction stream.
- Accepts 33-bit instruction words through a valid/ready handshake and buffers them in a small FIFO.
- Pairs each const_a instruction with the constant word that follows it.
- Drives every datapath control port and owns the zero_reg configuration register.

Parameters:
- DEPTH, 4, FIFO entries; must be >= 2 so an instruction and its constant fit together.
- CNT_W, 16, width of issue_count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_word  in  33  instruction word, or a constant word in bits [31:0].
- run  in  1  issue enable; 0 = hold issue, FIFO still fills.
- flush  in  1  discard all buffered words.
- cfg_we  in  1  load cfg_zero_reg into zero_reg.
- cfg_zero_reg  in  4  new zero_reg value.
- op  out  3  datapath op.
- form  out  1  datapath form.
- vec  out  2  datapath vec.
- A, B, C, D  out  4 each  source register indices.
- Y1, Y2  out  4 each  destination register indices.
- write  out  2  destination write enables.
- const_a  out  1  select constant as operand A.
- constant  out  32  constant value.
- zero_reg  out  4  zero-register configuration.
- issued  out  1  one-cycle pulse; outputs hold a live instruction this cycle.
- busy  out  1  FIFO non-empty.
- issue_count  out  CNT_W  instructions issued; wraps modulo 2^CNT_W.

Behaviour:
- Instruction field map: [32] const_a, [31:29] op, [28] form, [27:26] vec, [25:22] A, [21:18] B, [17:14] C, [13:10] D, [9:6] Y1, [5:2] Y2, [1:0] write.
- Reset (rst_n low at a rising edge):
  - FIFO empty, state S_IDLE.
  - All datapath outputs 0, zero_reg = 4'h0.
  - issued = 0, issue_count = 0, in_ready = 1 on the following cycle.
- Push: a word is stored at an edge where in_valid && in_ready.
  - in_ready = (count < DEPTH), taken from registered count; no same-cycle fall-through.
  - Push and pop in the same cycle are allowed.
- Head pairing:
  - Head with const_a = 0 is issuable when count >= 1.
  - Head with const_a = 1 is issuable only when count >= 2; the next entry supplies constant = entry[31:0], and entry[32] is ignored.
- FSM:
  - S_IDLE: count == 0 or run == 0.
  - S_WAIT_CONST: run == 1, head const_a = 1, count == 1.
  - S_RUN: head issuable and run == 1.
  - Transitions are re-evaluated every cycle from count, head and run.
- Issue, at an edge in S_RUN:
  - Pop 1 entry, or 2 for const_a.
  - Register all decoded fields onto the outputs and set issued = 1 for the next cycle; the datapath samples them at the following edge.
  - Latency: word accepted at edge N, earliest issue at edge N+1, visible on outputs in cycle N+1 to N+2.
  - Throughput: 1 instruction per cycle.
- No issue at an edge:
  - write = 0, const_a = 0, issued = 0.
  - op, form, vec, A, B, C, D, Y1, Y2 and constant are set to 0, so the datapath never sees a stale write.
- issue_count increments on each issue edge.
- flush has priority over push and pop at the same edge:
  - FIFO emptied; any same-cycle push is dropped.
  - No issue at that edge; outputs go to the idle values.
- run falling: takes effect at the next edge; an instruction already registered on the outputs completes normally.
- cfg_we: zero_reg <= cfg_zero_reg at the edge. It is legal at any time and applies to every datapath cycle after that edge.
- Reset mid-stream: everything returns to the reset values above, regardless of FIFO contents or state.

Decomposition:
- Shared package datapath_pkg:
  - Field bit positions (INSTR_W = 33, CONST_A_BIT, OP_MSB/LSB, etc.).
  - REG_IDX_W = 4.
  - State encoding S_IDLE / S_RUN / S_WAIT_CONST.
- One sub-module, seq_fifo:
  - Parameterised DEPTH × width, synchronous, single clock.
  - Exposes count, head and head+1 entries, push, and pop of 0/1/2 entries, with flush.

Test Plan:
- Reset then push one word {const_a=0, op=3, A=2, B=4, Y1=7, write=1} with run=1 -> issued=1 one cycle after acceptance with op=3, A=2, B=4, Y1=7, write=1; next cycle write=0; issue_count=1.
- Push {const_a=1, Y1=1, write=1}, then after 3 idle cycles push 32'd5 -> state S_WAIT_CONST, no issue until the constant is accepted; then one issue with const_a=1, constant=5, Y1=1; datapath register 1 reads 5 two cycles later.
- run=0, push 4 words -> in_ready=0 after 4 accepts, no issue; set run=1 -> 4 back-to-back issued pulses in program order; in_ready returns high the cycle after the first pop.
- FIFO holding 3 words, assert flush with in_valid=1 -> busy=0 next cycle, pushed word dropped, no issue, issue_count unchanged.
- cfg_we=1, cfg_zero_reg=4'hE while issuing -> zero_reg=4'hE from the next cycle; instruction issue unaffected.
- rst_n=0 for 1 edge while 2 words are buffered and an issue is on the outputs -> all outputs 0, busy=0, issue_count=0, in_ready=1 afterwards.
